// File: rtl/usb_rx_pkg.sv
// Shared USB full-speed receive definitions: line states, receiver FSM states,
// default bit timing and the raw-pin line classifier used by the RX front end.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        LINE_J,
        LINE_K,
        LINE_SE0,
        LINE_SE1
    } line_t;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        SE0_SEEN,
        WAIT_IDLE
    } rx_state_t;

    localparam int CLKS_PER_BIT_DEF = 8;
    localparam int SAMPLE_POINT_DEF = 3;
    localparam int STUFF_LIMIT_DEF  = 6;

    function automatic line_t classifyLine(input logic dp, input logic dm);
        line_t l;
        case ({dp, dm})
            2'b10:   l = LINE_J;
            2'b01:   l = LINE_K;
            2'b00:   l = LINE_SE0;
            default: l = LINE_SE1;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/nrzi_line_sync.sv
// Two-flop synchronizer for the raw D+/D- pads plus classification of the
// synchronized pair into a line state; resets to the idle J state.
module nrzi_line_sync
    import usb_rx_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_dPlus,
    input  logic  i_dMinus,
    output line_t o_line
);

    logic [1:0] r_meta;
    logic [1:0] r_sync;

    // Both flops reset to J so a reset never looks like a line transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 2'b10;
            r_sync <= 2'b10;
        end else begin
            r_meta <= {i_dPlus, i_dMinus};
            r_sync <= r_meta;
        end
    end

    assign o_line = classifyLine(r_sync[1], r_sync[0]);

endmodule

// File: rtl/nrzi_decode.sv
// USB full-speed receive front end: oversampled bit recovery with J/K resync,
// NRZI decode, bit unstuffing and EOP / error detection.
module nrzi_decode
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int SAMPLE_POINT = SAMPLE_POINT_DEF,
    parameter int STUFF_LIMIT  = STUFF_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic d_plus,
    input  logic d_minus,
    output logic d_orig,
    output logic bit_valid,
    output logic eop,
    output logic rx_err,
    output logic rx_active
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int OW = $clog2(STUFF_LIMIT + 1);

    line_t          w_line;
    line_t          r_lineDly;
    line_t          r_prevLine;
    line_t          w_prevLineNext;
    rx_state_t      r_state;
    rx_state_t      w_stateNext;
    logic [TW-1:0]  r_timer;
    logic [TW-1:0]  w_timer;
    logic [TW-1:0]  w_timerNext;
    logic [TW-1:0]  r_jCnt;
    logic [TW-1:0]  w_jCntNext;
    logic [OW-1:0]  r_onesCnt;
    logic [OW-1:0]  w_onesCntNext;
    logic           r_dOrig;
    logic           r_bitValid;
    logic           r_eop;
    logic           r_rxErr;
    logic           w_dOrigNext;
    logic           w_bitValidNext;
    logic           w_eopNext;
    logic           w_rxErrNext;
    logic           w_jkChange;
    logic           w_sample;
    logic           w_bitVal;

    nrzi_line_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .i_dPlus  (d_plus),
        .i_dMinus (d_minus),
        .o_line   (w_line)
    );

    // The cycle in which a J<->K edge first appears counts as timer 0.
    assign w_jkChange  = ((w_line == LINE_J) && (r_lineDly == LINE_K)) ||
                         ((w_line == LINE_K) && (r_lineDly == LINE_J));
    assign w_timer     = ((r_state == IDLE) || w_jkChange) ? '0 : r_timer;
    assign w_timerNext = (w_timer == TW'(CLKS_PER_BIT - 1)) ? '0 : w_timer + 1'b1;
    assign w_sample    = (w_timer == TW'(SAMPLE_POINT));
    assign w_bitVal    = (w_line == r_prevLine);

    always_comb begin
        w_stateNext    = r_state;
        w_prevLineNext = r_prevLine;
        w_onesCntNext  = r_onesCnt;
        w_jCntNext     = '0;
        w_dOrigNext    = 1'b0;
        w_bitValidNext = 1'b0;
        w_eopNext      = 1'b0;
        w_rxErrNext    = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_prevLineNext = LINE_J;
                w_onesCntNext  = '0;
                if (w_line == LINE_K) begin
                    w_stateNext = ACTIVE;
                end
            end

            ACTIVE: begin
                if (w_sample) begin
                    case (w_line)
                        LINE_J, LINE_K: begin
                            w_prevLineNext = w_line;
                            if (r_onesCnt == OW'(STUFF_LIMIT)) begin
                                // A full run of ones must be followed by a stuffed 0.
                                w_onesCntNext = '0;
                                if (w_bitVal) begin
                                    w_rxErrNext = 1'b1;
                                    w_stateNext = WAIT_IDLE;
                                end
                            end else begin
                                w_dOrigNext    = w_bitVal;
                                w_bitValidNext = 1'b1;
                                w_onesCntNext  = w_bitVal ? r_onesCnt + 1'b1 : '0;
                            end
                        end
                        LINE_SE0: w_stateNext = SE0_SEEN;
                        default: begin
                            w_rxErrNext = 1'b1;
                            w_stateNext = WAIT_IDLE;
                        end
                    endcase
                end
            end

            SE0_SEEN: begin
                if (w_sample) begin
                    case (w_line)
                        LINE_SE0: w_stateNext = SE0_SEEN;
                        LINE_J: begin
                            w_eopNext      = 1'b1;
                            w_prevLineNext = LINE_J;
                            w_onesCntNext  = '0;
                            w_stateNext    = IDLE;
                        end
                        default: begin
                            w_rxErrNext = 1'b1;
                            w_stateNext = WAIT_IDLE;
                        end
                    endcase
                end
            end

            WAIT_IDLE: begin
                // Require a full bit time of uninterrupted J before rearming.
                if (w_line == LINE_J) begin
                    if (r_jCnt == TW'(CLKS_PER_BIT - 1)) begin
                        w_stateNext = IDLE;
                    end else begin
                        w_jCntNext = r_jCnt + 1'b1;
                    end
                end
            end

            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_lineDly  <= LINE_J;
            r_prevLine <= LINE_J;
            r_timer    <= '0;
            r_jCnt     <= '0;
            r_onesCnt  <= '0;
            r_dOrig    <= 1'b0;
            r_bitValid <= 1'b0;
            r_eop      <= 1'b0;
            r_rxErr    <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_lineDly  <= w_line;
            r_prevLine <= w_prevLineNext;
            r_timer    <= (w_stateNext == IDLE) ? '0 : w_timerNext;
            r_jCnt     <= w_jCntNext;
            r_onesCnt  <= w_onesCntNext;
            r_dOrig    <= w_dOrigNext;
            r_bitValid <= w_bitValidNext;
            r_eop      <= w_eopNext;
            r_rxErr    <= w_rxErrNext;
        end
    end

    assign d_orig    = r_dOrig;
    assign bit_valid = r_bitValid;
    assign eop       = r_eop;
    assign rx_err    = r_rxErr;
    assign rx_active = (r_state != IDLE);

endmodule

// File: tb/tb_nrzi_decode.sv
// Directed bench for nrzi_decode: drives line symbols per bit time and compares
// the decoded bit stream and eop/rx_err pulses with hand-computed expectations.
module tb_nrzi_decode;

    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic d_plus = 1'b1;
    logic d_minus = 1'b0;
    logic d_orig;
    logic bit_valid;
    logic eop;
    logic rx_err;
    logic rx_active;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int eopTotal = 0;
    int errTotal = 0;
    int multiCnt = 0;
    logic bitQ[$];
    int cycQ[$];

    int bitBase;
    int eopBase;
    int errBase;
    int t0;

    nrzi_decode dut (
        .clk       (clk),
        .rst       (rst),
        .d_plus    (d_plus),
        .d_minus   (d_minus),
        .d_orig    (d_orig),
        .bit_valid (bit_valid),
        .eop       (eop),
        .rx_err    (rx_err),
        .rx_active (rx_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Outputs are registered on posedge, so they are observed on negedge.
    always @(negedge clk) begin
        if (bit_valid) begin
            bitQ.push_back(d_orig);
            cycQ.push_back(cyc);
        end
        if (eop) eopTotal++;
        if (rx_err) errTotal++;
        if ((int'(bit_valid) + int'(eop) + int'(rx_err)) > 1) multiCnt++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] sym, input int clks);
        {d_plus, d_minus} = sym;
        repeat (clks) @(negedge clk);
    endtask

    function automatic logic [1:0] symOf(input byte c);
        case (c)
            "J":     return SYM_J;
            "K":     return SYM_K;
            "0":     return SYM_SE0;
            default: return 2'b11;
        endcase
    endfunction

    task automatic sendLevels(input string s, input int cpb);
        for (int i = 0; i < s.len(); i++) begin
            applyStimulus(symOf(s[i]), cpb);
        end
    endtask

    task automatic startTest();
        bitBase = bitQ.size();
        eopBase = eopTotal;
        errBase = errTotal;
    endtask

    task automatic checkBits(input string tag, input string exp);
        logic [63:0] obs;
        logic [63:0] want;
        int n;
        obs = '0;
        want = '0;
        n = bitQ.size() - bitBase;
        checkOutput({tag, "_count"}, 64'(n), 64'(exp.len()));
        for (int i = bitBase; i < bitQ.size(); i++) obs = {obs[62:0], bitQ[i]};
        for (int i = 0; i < exp.len(); i++) want = {want[62:0], (exp[i] == "1")};
        checkOutput({tag, "_bits"}, obs, want);
    endtask

    task automatic checkPulses(input string tag, input int expEop, input int expErr);
        checkOutput({tag, "_eop"}, 64'(eopTotal - eopBase), 64'(expEop));
        checkOutput({tag, "_err"}, 64'(errTotal - errBase), 64'(expErr));
        checkOutput({tag, "_rx_active_end"}, 64'(rx_active), 64'(0));
    endtask

    initial begin
        applyStimulus(SYM_J, 3);
        checkOutput("reset_outputs", 64'({d_orig, bit_valid, eop, rx_err, rx_active}), 64'(0));
        rst = 1'b0;
        applyStimulus(SYM_J, 10);

        $display("[TB] mid-packet reset");
        startTest();
        sendLevels("KJKJ", 8);
        checkOutput("t1_active_before_reset", 64'(rx_active), 64'(1));
        rst = 1'b1;
        applyStimulus(SYM_J, 2);
        checkOutput("t1_outputs_in_reset",
                    64'({d_orig, bit_valid, eop, rx_err, rx_active}), 64'(0));
        rst = 1'b0;
        applyStimulus(SYM_J, 20);
        checkPulses("t1_abort", 0, 0);
        startTest();
        sendLevels("KJKJKJKK", 8);
        sendLevels("00", 8);
        applyStimulus(SYM_J, 24);
        checkBits("t1_restart", "00000001");
        checkPulses("t1_restart", 1, 0);

        $display("[TB] sync pattern and latency");
        startTest();
        t0 = cyc;
        sendLevels("KJKJKJKK", 8);
        checkOutput("t2_rx_active", 64'(rx_active), 64'(1));
        sendLevels("00", 8);
        applyStimulus(SYM_J, 24);
        checkBits("t2_sync", "00000001");
        checkOutput("t2_latency",
                    (bitQ.size() > bitBase) ? 64'(cycQ[bitBase] - t0) : 64'(-1), 64'(6));
        checkPulses("t2_sync", 1, 0);

        $display("[TB] bit stuffing");
        startTest();
        sendLevels("KJKJKJKKKKKKKJJKKJ", 8);
        sendLevels("00", 8);
        applyStimulus(SYM_J, 24);
        checkBits("t3_stuff", "00000001111111010");
        checkPulses("t3_stuff", 1, 0);

        $display("[TB] stuff violation");
        startTest();
        sendLevels("KJKJKJKKKKKKKK", 8);
        sendLevels("KK", 8);
        applyStimulus(SYM_J, 4);
        checkOutput("t4_waiting", 64'(rx_active), 64'(1));
        applyStimulus(SYM_K, 8);
        applyStimulus(SYM_J, 24);
        checkBits("t4_stufferr", "0000000111111");
        checkPulses("t4_stufferr", 0, 1);

        $display("[TB] K after SE0");
        startTest();
        sendLevels("KJKJKJKK00K", 8);
        applyStimulus(SYM_J, 24);
        checkBits("t5_kse0", "00000001");
        checkPulses("t5_kse0", 0, 1);

        $display("[TB] SE1 in packet");
        startTest();
        sendLevels("KJKJKJKK1", 8);
        applyStimulus(SYM_J, 24);
        checkBits("t5_se1", "00000001");
        checkPulses("t5_se1", 0, 1);

        $display("[TB] slow bit rate");
        startTest();
        sendLevels("KJKJKJKKJJKJKKJKJJKKJKJK", 9);
        applyStimulus(SYM_SE0, 16);
        applyStimulus(SYM_J, 24);
        checkBits("t6_slow", "000000010100010001010000");
        checkPulses("t6_slow", 1, 0);

        $display("[TB] fast bit rate");
        startTest();
        sendLevels("KJKJKJKKJJKJKKJKJJKKJKJK", 7);
        applyStimulus(SYM_SE0, 16);
        applyStimulus(SYM_J, 24);
        checkBits("t6_fast", "000000010100010001010000");
        checkPulses("t6_fast", 1, 0);

        checkOutput("exclusive_pulses", 64'(multiCnt), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
